// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the program-counter generator.
//   - Control-level constants (reset, chip enable, stall, branch prediction)
//   - Startup FSM state encoding
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic NoStop      = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;

    // Startup sequence: RESET -> WARM -> RUN. Fetch is enabled only in RUN.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_WARM  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: request/fetch bundle between control logic and pc_gen.
//   master : control/exception side, drives redirects and BTB updates,
//            observes pc, ce, pred_taken
//   slave  : pc_gen itself
interface pc_gen_if #(
    parameter int ADDR_W = 32
);

    logic              exc_valid;
    logic [ADDR_W-1:0] exc_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              btb_upd_valid;
    logic [ADDR_W-1:0] btb_upd_pc;
    logic [ADDR_W-1:0] btb_upd_target;
    logic              btb_upd_taken;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              pred_taken;

    modport master (
        output exc_valid, exc_pc, redirect_valid, redirect_pc,
               btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        input  pc, ce, pred_taken
    );

    modport slave (
        input  exc_valid, exc_pc, redirect_valid, redirect_pc,
               btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        output pc, ce, pred_taken
    );

endinterface

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer.
//   clk, rst       : clock, async active-high reset (clears valid bits only)
//   rdy_in         : global ready, updates ignored while low
//   lookup_pc      : address to look up (combinational hit/target)
//   hit, target    : lookup result
//   upd_*          : update from branch resolution
// Index is pc[IDX_W+1:2]; tag is the remaining upper bits.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic [ADDR_W-1:0] target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [ADDR_W-1:0]      target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic [3:0]       byte_offset_unused;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Instructions are word aligned, so the byte offset never participates.
    assign byte_offset_unused = {lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered arrays, so a same-cycle update is not seen.
    assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign target = target_q[lk_idx];

    // Valid bits: set on taken, cleared on not-taken only for the same branch,
    // so an aliasing branch cannot evict an entry by resolving not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else if (upd_valid && rdy_in) begin
            if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
            end else if (tag_q[up_idx] == up_tag) begin
                valid_q[up_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload needs no reset; valid gates its use.
    always_ff @(posedge clk) begin
        if (upd_valid && rdy_in && upd_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for instruction fetch.
//   clk, rst  : clock, async active-high reset
//   rdy_in    : global ready, 0 freezes all state
//   stall     : pipeline stall vector, bit 0 holds the PC
//   bus       : pc_gen_if slave -- exception/redirect requests, BTB updates,
//               and the fetch outputs pc, ce, pred_taken
// Next-PC priority: pending exception, exception, pending redirect,
// redirect, BTB predicted target, pc+STEP.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                STEP        = 4,
    parameter int                STALL_W     = 6,
    parameter int                BTB_ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy_in,
    input  logic [STALL_W-1:0] stall,
    pc_gen_if.slave            bus
);

    state_t            state_q;
    logic              ce_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pend_valid_q;
    logic              pend_exc_q;
    logic [ADDR_W-1:0] pend_pc_q;

    logic              run;
    logic              advance;
    logic              held;
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_target;
    logic [ADDR_W-1:0] next_pc;
    logic              stall_unused;

    // Only stall[0] matters to the fetch stage.
    assign stall_unused = ^stall;

    assign run     = (state_q == ST_RUN);
    assign advance = run && rdy_in && (stall[0] == NoStop);
    assign held    = run && rdy_in && (stall[0] == Stop);

    pc_btb #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rdy_in     (rdy_in),
        .lookup_pc  (pc_q),
        .hit        (btb_hit),
        .target     (btb_target),
        .upd_valid  (bus.btb_upd_valid),
        .upd_pc     (bus.btb_upd_pc),
        .upd_target (bus.btb_upd_target),
        .upd_taken  (bus.btb_upd_taken)
    );

    // A held request only outranks new requests of a lower class: a pending
    // exception beats everything, a pending redirect loses to a new exception.
    always_comb begin
        next_pc = pc_q + ADDR_W'(STEP);
        if (pend_valid_q && pend_exc_q) begin
            next_pc = pend_pc_q;
        end else if (bus.exc_valid) begin
            next_pc = bus.exc_pc;
        end else if (pend_valid_q) begin
            next_pc = pend_pc_q;
        end else if (bus.redirect_valid) begin
            next_pc = bus.redirect_pc;
        end else if (btb_hit) begin
            next_pc = btb_target;
        end
    end

    // Startup FSM, PC register and pending-request register. Requests seen
    // while held are parked so they are not lost; a newer redirect never
    // displaces a parked exception.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q      <= ST_RESET;
            ce_q         <= ChipDisable;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_exc_q   <= 1'b0;
            pend_pc_q    <= '0;
        end else if (rdy_in) begin
            case (state_q)
                ST_RESET: begin
                    state_q <= ST_WARM;
                    ce_q    <= ChipDisable;
                end
                ST_WARM: begin
                    state_q <= ST_RUN;
                    ce_q    <= ChipEnable;
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                    ce_q    <= ChipEnable;
                end
                default: begin
                    state_q <= ST_RESET;
                    ce_q    <= ChipDisable;
                end
            endcase

            if (advance) begin
                pc_q         <= next_pc;
                pend_valid_q <= 1'b0;
            end else if (held) begin
                if (bus.exc_valid) begin
                    pend_valid_q <= 1'b1;
                    pend_exc_q   <= 1'b1;
                    pend_pc_q    <= bus.exc_pc;
                end else if (bus.redirect_valid && !(pend_valid_q && pend_exc_q)) begin
                    pend_valid_q <= 1'b1;
                    pend_exc_q   <= 1'b0;
                    pend_pc_q    <= bus.redirect_pc;
                end
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ce         = ce_q;
    assign bus.pred_taken = (btb_hit && (ce_q == ChipEnable)) ? Branch : NotBranch;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. Directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the fetch
// address sequence, pending request and BTB.
module tb_pc_gen;

    localparam int                ADDR_W      = 16;
    localparam int                STALL_W     = 6;
    localparam int                BTB_ENTRIES = 16;
    localparam int                STEP        = 4;
    localparam logic [ADDR_W-1:0] RESET_PC    = 16'h0000;
    localparam int                ADDR_SPAN   = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               rdy_in;
    logic [STALL_W-1:0] stall;

    pc_gen_if #(.ADDR_W(ADDR_W)) bus ();

    pc_gen #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    (RESET_PC),
        .STEP        (STEP),
        .STALL_W     (STALL_W),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rdy_in (rdy_in),
        .stall  (stall),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 rdy;
        bit [STALL_W-1:0]   stall;
        bit                 exc_v;
        int                 exc_pc;
        bit                 red_v;
        int                 red_pc;
        bit                 upd_v;
        int                 upd_pc;
        int                 upd_tgt;
        bit                 upd_taken;
    } stim_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_edges;
    int m_pc;
    bit p_valid;
    bit p_exc;
    int p_pc;
    bit b_valid [BTB_ENTRIES];
    int b_br    [BTB_ENTRIES];
    int b_tgt   [BTB_ENTRIES];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s.rdy = 1'b1; s.stall = '0;
        s.exc_v = 1'b0; s.exc_pc = 0;
        s.red_v = 1'b0; s.red_pc = 0;
        s.upd_v = 1'b0; s.upd_pc = 0; s.upd_tgt = 0; s.upd_taken = 1'b0;
        return s;
    endfunction

    function automatic int btb_idx(input int a);
        return (a / 4) % BTB_ENTRIES;
    endfunction

    function automatic int btb_key(input int a);
        return a / (4 * BTB_ENTRIES);
    endfunction

    function automatic bit model_hit(input int a);
        int i;
        i = btb_idx(a);
        return b_valid[i] && (btb_key(b_br[i]) == btb_key(a));
    endfunction

    function automatic void model_reset();
        m_edges = 0;
        m_pc    = int'(RESET_PC);
        p_valid = 1'b0;
        p_exc   = 1'b0;
        p_pc    = 0;
        for (int i = 0; i < BTB_ENTRIES; i++) b_valid[i] = 1'b0;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    function automatic void model_clock(input stim_t s);
        bit was_run;
        int i;
        if (rst) begin
            model_reset();
            return;
        end
        if (!s.rdy) return;
        was_run = (m_edges >= 2);
        if (!was_run) begin
            m_edges++;
        end else if (!s.stall[0]) begin
            if (p_valid && p_exc)   m_pc = p_pc;
            else if (s.exc_v)       m_pc = s.exc_pc;
            else if (p_valid)       m_pc = p_pc;
            else if (s.red_v)       m_pc = s.red_pc;
            else if (model_hit(m_pc)) m_pc = b_tgt[btb_idx(m_pc)];
            else                    m_pc = (m_pc + STEP) % ADDR_SPAN;
            p_valid = 1'b0;
        end else begin
            if (s.exc_v) begin
                p_valid = 1'b1; p_exc = 1'b1; p_pc = s.exc_pc;
            end else if (s.red_v && !(p_valid && p_exc)) begin
                p_valid = 1'b1; p_exc = 1'b0; p_pc = s.red_pc;
            end
        end
        if (s.upd_v) begin
            i = btb_idx(s.upd_pc);
            if (s.upd_taken) begin
                b_valid[i] = 1'b1; b_br[i] = s.upd_pc; b_tgt[i] = s.upd_tgt;
            end else if (btb_key(b_br[i]) == btb_key(s.upd_pc)) begin
                b_valid[i] = 1'b0;
            end
        end
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle against the model,
    // then step the model and return just after the rising edge.
    task automatic applyStimulus(input stim_t s);
        rdy_in             = s.rdy;
        stall              = s.stall;
        bus.exc_valid      = s.exc_v;
        bus.exc_pc         = ADDR_W'(s.exc_pc);
        bus.redirect_valid = s.red_v;
        bus.redirect_pc    = ADDR_W'(s.red_pc);
        bus.btb_upd_valid  = s.upd_v;
        bus.btb_upd_pc     = ADDR_W'(s.upd_pc);
        bus.btb_upd_target = ADDR_W'(s.upd_tgt);
        bus.btb_upd_taken  = s.upd_taken;
        @(negedge clk);
        checkOutput("pc", 32'(bus.pc), 32'(m_pc));
        checkOutput("ce", 32'(bus.ce), 32'(m_edges >= 2));
        checkOutput("pred_taken", 32'(bus.pred_taken), 32'((m_edges >= 2) && model_hit(m_pc)));
        model_clock(s);
        @(posedge clk);
        #1;
    endtask

    task automatic quietCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(quiet());
    endtask

    initial begin
        stim_t s;
        rst = 1'b1;
        model_reset();

        // Reset and startup
        quietCycles(3);
        rst = 1'b0;
        quietCycles(2);
        checkOutput("startup_ce", 32'(bus.ce), 32'd1);
        checkOutput("startup_pc", 32'(bus.pc), 32'h0);
        quietCycles(4);
        checkOutput("seq_pc", 32'(bus.pc), 32'h10);

        // Stall with a redirect parked
        s = quiet(); s.stall = 6'b000001; s.red_v = 1'b1; s.red_pc = 'h200;
        applyStimulus(s);
        s = quiet(); s.stall = 6'b000001;
        for (int k = 0; k < 3; k++) applyStimulus(s);
        checkOutput("stall_hold", 32'(bus.pc), 32'h10);
        quietCycles(1);
        checkOutput("pend_redirect", 32'(bus.pc), 32'h200);
        quietCycles(1);
        checkOutput("after_redirect", 32'(bus.pc), 32'h204);

        // Priority
        s = quiet(); s.exc_v = 1'b1; s.exc_pc = 'h80; s.red_v = 1'b1; s.red_pc = 'h300;
        applyStimulus(s);
        checkOutput("exc_over_redir", 32'(bus.pc), 32'h80);
        quietCycles(1);
        s = quiet(); s.stall = 6'b000001; s.exc_v = 1'b1; s.exc_pc = 'h80;
        applyStimulus(s);
        s = quiet(); s.stall = 6'b000001; s.red_v = 1'b1; s.red_pc = 'h300;
        applyStimulus(s);
        quietCycles(1);
        checkOutput("pend_exc_wins", 32'(bus.pc), 32'h80);

        // BTB taken
        s = quiet(); s.red_v = 1'b1; s.red_pc = 'h30;
        s.upd_v = 1'b1; s.upd_pc = 'h40; s.upd_tgt = 'h100; s.upd_taken = 1'b1;
        applyStimulus(s);
        quietCycles(4);
        checkOutput("btb_at_40", 32'(bus.pc), 32'h40);
        checkOutput("btb_pred", 32'(bus.pred_taken), 32'd1);
        quietCycles(1);
        checkOutput("btb_target", 32'(bus.pc), 32'h100);

        // BTB not taken clears the entry
        s = quiet(); s.red_v = 1'b1; s.red_pc = 'h40;
        s.upd_v = 1'b1; s.upd_pc = 'h40; s.upd_taken = 1'b0;
        applyStimulus(s);
        checkOutput("btb_cleared_pred", 32'(bus.pred_taken), 32'd0);
        quietCycles(1);
        checkOutput("btb_cleared_next", 32'(bus.pc), 32'h44);

        // Aliasing address misses, original still hits
        s = quiet(); s.red_v = 1'b1; s.red_pc = 'h40 + 4 * BTB_ENTRIES;
        s.upd_v = 1'b1; s.upd_pc = 'h40; s.upd_tgt = 'h100; s.upd_taken = 1'b1;
        applyStimulus(s);
        checkOutput("alias_pred", 32'(bus.pred_taken), 32'd0);
        quietCycles(1);
        checkOutput("alias_next", 32'(bus.pc), 32'h84);
        s = quiet(); s.red_v = 1'b1; s.red_pc = 'h40;
        applyStimulus(s);
        checkOutput("orig_still_hits", 32'(bus.pred_taken), 32'd1);

        // Wrap-around
        s = quiet(); s.red_v = 1'b1; s.red_pc = ADDR_SPAN - 8;
        applyStimulus(s);
        quietCycles(2);
        checkOutput("wrap", 32'(bus.pc), 32'h0);

        // rdy_in low freezes everything, requests ignored
        s = quiet(); s.rdy = 1'b0; s.red_v = 1'b1; s.red_pc = 'h500;
        for (int k = 0; k < 4; k++) applyStimulus(s);
        checkOutput("rdy_freeze", 32'(bus.pc), 32'h0);
        quietCycles(1);
        checkOutput("rdy_resume", 32'(bus.pc), 32'h4);

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            s = quiet();
            s.rdy       = ($urandom_range(0, 99) < 85);
            s.stall     = STALL_W'($urandom);
            s.stall[0]  = ($urandom_range(0, 99) < 30);
            s.exc_v     = ($urandom_range(0, 99) < 5);
            s.exc_pc    = int'($urandom_range(0, 255)) * 4;
            s.red_v     = ($urandom_range(0, 99) < 12);
            s.red_pc    = int'($urandom_range(0, 255)) * 4;
            s.upd_v     = ($urandom_range(0, 99) < 25);
            s.upd_pc    = (m_pc + 4 * int'($urandom_range(0, 3))) % ADDR_SPAN;
            s.upd_tgt   = int'($urandom_range(0, 255)) * 4;
            s.upd_taken = ($urandom_range(0, 99) < 70);
            applyStimulus(s);
        end

        // Asynchronous reset mid-run
        quietCycles(3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput("async_rst_pc", 32'(bus.pc), 32'(RESET_PC));
        checkOutput("async_rst_ce", 32'(bus.ce), 32'd0);
        checkOutput("async_rst_pred", 32'(bus.pred_taken), 32'd0);
        quietCycles(2);
        rst = 1'b0;
        quietCycles(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage; next generation of the single-width PC register. Produces the fetch address each cycle and selects the next address by a fixed priority: exception vector, branch/jump redirect, BTB-predicted target, sequential increment. Holds on pipeline stall or memory not-ready. Latches redirects that arrive while held so none is lost. Sits between the control/exception logic and the instruction-fetch interface.

## Interface
Parameters:
- ADDR_W, 32, width of PC and all address ports
- RESET_PC, 0, PC value held during and after reset
- STEP, 4, sequential increment in bytes
- STALL_W, 6, width of the pipeline stall vector; only bit 0 is used here
- BTB_ENTRIES, 16, direct-mapped BTB entries; power of 2, ≥2

Ports (clock and reset first):
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global ready; 0 freezes all state except reset
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds the PC
- exc_valid  in  1  exception/trap redirect request
- exc_pc  in  ADDR_W  exception target address
- redirect_valid  in  1  resolved branch/jump redirect request
- redirect_pc  in  ADDR_W  redirect target; used as the next fetch address exactly, with no offset added
- btb_upd_valid  in  1  BTB update from branch resolution
- btb_upd_pc  in  ADDR_W  address of the resolved branch
- btb_upd_target  in  ADDR_W  resolved target
- btb_upd_taken  in  1  resolved direction
- pc  out  ADDR_W  current fetch address
- ce  out  1  fetch enable
- pred_taken  out  1  current pc hit in BTB; next pc is the predicted target

## Operation
- Startup FSM with states RESET, WARM, RUN.
  - RESET: entered asynchronously on rst.
  - RESET→WARM on the first clk edge after rst is released.
  - WARM→RUN on the next edge.
  - ce=0 in RESET and WARM, ce=1 in RUN.
  - rdy_in=0 stalls FSM transitions.
- advance = RUN & rdy_in & ~stall[0].
- On advance, next pc is selected in priority order:
  - pending exception
  - exc_valid
  - pending redirect
  - redirect_valid
  - BTB hit (target)
  - pc+STEP
- A same-cycle input outranks a pending request of a lower class only. A pending exception beats a new redirect.
- When a redirect or exception arrives and advance=0 (RUN, rdy_in=1), it is latched into the pending register: pend_valid, pend_exc, pend_pc.
  - A newer exception overwrites any pending entry.
  - A newer redirect overwrites a pending redirect only, never a pending exception.
- The pending register clears on the advance that consumes it.
- Requests arriving while ce=0 are ignored.
- Arithmetic: pc+STEP is modulo 2^ADDR_W, so wrap-around from all-ones is legal.
- BTB organisation:
  - Index = pc[log2(BTB_ENTRIES)+1:2].
  - Tag = remaining upper bits.
  - Each entry holds valid, tag and target.
- Hit = valid & tag match on the current pc, combinational; pred_taken=hit&ce.
- BTB update when btb_upd_valid & rdy_in:
  - taken: write valid=1, tag and target.
  - not taken: clear valid only if the tag matches.
- A same-cycle lookup and update to the same index sees the old contents.

## Timing
- Reset values:
  - pc=RESET_PC, ce=0, pred_taken=0.
  - FSM=RESET, pending cleared, all BTB valid bits 0.
- Reset takes effect immediately, mid-operation included.
- ce rises 2 edges after rst falls, with rdy_in=1 throughout.
- The first pc+STEP occurs on the edge after ce=1.
- Redirect latency:
  - Request in cycle N with advance=1 gives pc=target in N+1.
  - If held, pc=target on the edge ending the first cycle with advance=1.
- BTB update in cycle N is visible to lookups from N+1.
- rdy_in=0: pc, FSM, pending and BTB all unchanged.

## Structure
- Shared defines file holds RstEnable, ChipEnable/ChipDisable, NoStop/Stop, Branch/NotBranch, and FSM state encodings.
- One sub-module, pc_btb: storage plus lookup and update ports, parametrised by ADDR_W and BTB_ENTRIES.
- pc_gen holds the FSM, pending register and next-PC mux.

## Test plan
- Reset/startup: rst high 3 cycles, then low, rdy_in=1 → ce=0 for 2 edges; pc sequence 0,0,0,4,8.
- Stall and redirect hold: stall[0]=1 at pc=0x10, redirect_pc=0x200 pulsed one cycle, stall held 3 more cycles → pc stays 0x10; pc=0x200 the edge after stall drops, then 0x204.
- Priority: exc_valid (0x80) and redirect_valid (0x300) in the same cycle → pc=0x80.
  - Under stall: pending exception 0x80, then redirect 0x300 → pc=0x80 after release.
- BTB: update pc=0x40 target=0x100 taken → next visit to 0x40 gives pred_taken=1 and next pc=0x100.
  - Not-taken update to 0x40 → next visit gives 0x44.
  - Aliasing address 0x40+4·BTB_ENTRIES misses.
- Wrap and rdy: ADDR_W=8 with pc=0xFC → next pc=0x00.
  - rdy_in=0 for 4 cycles mid-run → pc frozen.
  - rst asserted mid-run → pc=RESET_PC, ce=0 immediately.
